// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: reset vector, PC increment, FSM encoding.
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_8000;
    localparam logic [31:0] PC_STEP  = 32'h0000_0004;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // Instruction fetches are word aligned; the low two address bits are cleared.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of predictor, hazard, ROM and decode-side signals around the fetch controller.
interface fetch_ctrl_if;

    logic        stall;
    logic [31:0] prepc;
    logic        hit_predict;
    logic [31:0] nextpc;
    logic        fail_predict;
    logic [31:0] rom_addr;
    logic [31:0] pcF;
    logic        validF;
    logic [31:0] pcD;
    logic [31:0] prednextD;
    logic        validD;

    // Environment side: drives control/predictor inputs, observes fetch outputs.
    modport master (
        output stall, prepc, hit_predict, nextpc, fail_predict,
        input  rom_addr, pcF, validF, pcD, prednextD, validD
    );

    // Fetch controller side.
    modport slave (
        input  stall, prepc, hit_predict, nextpc, fail_predict,
        output rom_addr, pcF, validF, pcD, prednextD, validD
    );

endinterface

// File: rtl/fd_reg.sv
// F->D pipeline register: carries PC, predicted next PC and valid bit into decode.
// A flush (misprediction) takes priority over a stall; a flush only clears the
// valid bit and leaves the payload untouched.
module fd_reg (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pred,
    input  logic        i_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pred,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_pred;
    logic        r_valid;

    // Decode slot update: flush clears valid, stall holds, otherwise capture fetch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc    <= 32'h0000_0000;
            r_pred  <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (!i_load) begin
            r_pc    <= r_pc;
            r_pred  <= r_pred;
            r_valid <= r_valid;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_stall) begin
            r_pc    <= r_pc;
            r_pred  <= r_pred;
            r_valid <= r_valid;
        end else begin
            r_pc    <= i_pc;
            r_pred  <= i_pred;
            r_valid <= i_valid;
        end
    end

    assign o_pc    = r_pc;
    assign o_pred  = r_pred;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: selects the next fetch address (redirect, prediction
// or sequential), holds pcF/validF and owns the F->D pipeline register.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic         CLK,
    input  logic         RSTN,
    fetch_ctrl_if.slave  bus
);

    fetch_state_e r_state;
    logic [31:0]  r_pc_f;
    logic         r_valid_f;

    logic [31:0]  w_pred_f;
    logic [31:0]  w_sel_addr;
    logic [31:0]  w_rom_addr;
    logic         w_run;
    logic [31:0]  w_pc_d;
    logic [31:0]  w_pred_d;
    logic         w_valid_d;

    // Predicted next PC for the instruction currently at pcF.
    always_comb begin
        w_pred_f = r_pc_f + PC_STEP;
        if (bus.hit_predict) begin
            w_pred_f = bus.prepc;
        end else begin
            w_pred_f = r_pc_f + PC_STEP;
        end
    end

    // Next fetch address: redirect beats stall, stall re-reads pcF, else prediction.
    always_comb begin
        w_sel_addr = RESET_PC;
        case (r_state)
            BOOT: w_sel_addr = RESET_PC;
            RUN: begin
                if (bus.fail_predict) begin
                    w_sel_addr = bus.nextpc;
                end else if (bus.stall) begin
                    w_sel_addr = r_pc_f;
                end else begin
                    w_sel_addr = w_pred_f;
                end
            end
            default: w_sel_addr = RESET_PC;
        endcase
        w_rom_addr = align_word(w_sel_addr);
    end

    // Boot/run sequencing with pcF and validF; pcF tracks the ROM address each RUN cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= BOOT;
            r_pc_f    <= RESET_PC;
            r_valid_f <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state   <= RUN;
                    r_pc_f    <= r_pc_f;
                    r_valid_f <= 1'b1;
                end
                RUN: begin
                    r_state   <= RUN;
                    r_pc_f    <= w_rom_addr;
                    r_valid_f <= 1'b1;
                end
                default: begin
                    r_state   <= BOOT;
                    r_pc_f    <= RESET_PC;
                    r_valid_f <= 1'b0;
                end
            endcase
        end
    end

    assign w_run = (r_state == RUN);

    fd_reg u_fd_reg (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_load  (w_run),
        .i_flush (bus.fail_predict),
        .i_stall (bus.stall),
        .i_pc    (r_pc_f),
        .i_pred  (w_pred_f),
        .i_valid (r_valid_f),
        .o_pc    (w_pc_d),
        .o_pred  (w_pred_d),
        .o_valid (w_valid_d)
    );

    assign bus.rom_addr  = w_rom_addr;
    assign bus.pcF       = r_pc_f;
    assign bus.validF    = r_valid_f;
    assign bus.pcD       = w_pc_d;
    assign bus.prednextD = w_pred_d;
    assign bus.validD    = w_valid_d;

endmodule
